// File: rtl/apb2axi_read_engine_if.sv
// AXI read address + read data channels of the read engine.
// master: engine side (drives AR, rready); slave: fabric side (drives arready, R).
interface apb2axi_read_engine_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4
);
  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/apb2axi_read_engine.sv
// Pops read entries, issues AXI AR bursts, tracks per-tag beats, streams R as completions.
// Ports: aclk/aresetn, rd_pop_*, axi (master), cpl_*, outst_cnt, drop_pulse, proto_err.
module apb2axi_read_engine #(
  parameter int AXI_ADDR_W   = 32,
  parameter int AXI_DATA_W   = 64,
  parameter int AXI_ID_W     = 4,
  parameter int MAX_OUTST    = 4,
  parameter int FIFO_ENTRY_W = AXI_ID_W + AXI_ADDR_W + 10
) (
  input  logic                              aclk,
  input  logic                              aresetn,

  input  logic                              rd_pop_valid,
  input  logic [FIFO_ENTRY_W-1:0]           rd_pop_data,
  output logic                              rd_pop_ready,

  apb2axi_read_engine_if.master             axi,

  output logic                              cpl_valid,
  input  logic                              cpl_ready,
  output logic [AXI_ID_W-1:0]               cpl_tag,
  output logic [AXI_DATA_W-1:0]             cpl_data,
  output logic [1:0]                        cpl_resp,
  output logic                              cpl_last,
  output logic                              cpl_err,

  output logic [$clog2(MAX_OUTST+1)-1:0]    outst_cnt,
  output logic                              drop_pulse,
  output logic                              proto_err
);

  localparam int NT    = 2 ** AXI_ID_W;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_OUTST);

  typedef struct packed {
    logic [AXI_ID_W-1:0]   tag;
    logic [AXI_ADDR_W-1:0] addr;
    logic [3:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  is_write;
  } directory_entry_t;

  directory_entry_t ent;
  assign ent = rd_pop_data;

  logic                  arvalid_q, arvalid_d;
  logic [AXI_ID_W-1:0]   arid_q, arid_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;

  logic [NT-1:0] busy_q, busy_d;
  logic [NT-1:0] err_q, err_d;
  logic [4:0]    exp_q [NT];
  logic [4:0]    exp_d [NT];
  logic [4:0]    cnt_q [NT];
  logic [4:0]    cnt_d [NT];

  logic [CNT_W-1:0] outst_q, outst_d;
  logic drop_q, proto_q;

  logic ar_hs, ar_free, accept, drop;
  logic rid_busy, r_hs, beat_acc, stray, retire;
  logic beat_bad, r_nok;
  logic [4:0] beat_n;

  assign ar_hs   = arvalid_q && axi.arready;
  assign ar_free = !arvalid_q || axi.arready;

  assign accept = rd_pop_valid && !ent.is_write && ar_free
               && (outst_q < MAXC) && !busy_q[ent.tag];
  assign drop   = rd_pop_valid && ent.is_write;
  assign rd_pop_ready = accept || drop;

  // Known tags are forwarded with zero latency; unknown ones are sunk.
  assign rid_busy  = busy_q[axi.rid];
  assign axi.rready = rid_busy ? cpl_ready : 1'b1;
  assign r_hs      = axi.rvalid && axi.rready;
  assign beat_acc  = r_hs && rid_busy;
  assign stray     = r_hs && !rid_busy;
  assign retire    = beat_acc && axi.rlast;
  assign r_nok     = axi.rresp != 2'b00;

  // Saturate so a runaway burst cannot wrap back to a legal count.
  assign beat_n = (cnt_q[axi.rid] == 5'd31) ? 5'd31
                : cnt_q[axi.rid] + 5'd1;

  assign beat_bad = axi.rlast ? (beat_n != exp_q[axi.rid])
                              : (beat_n > exp_q[axi.rid]);

  assign cpl_valid = axi.rvalid && rid_busy;
  assign cpl_tag   = axi.rid;
  assign cpl_data  = axi.rdata;
  assign cpl_resp  = axi.rresp;
  assign cpl_last  = axi.rlast;
  assign cpl_err   = axi.rlast && (err_q[axi.rid] || r_nok);

  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    if (accept) begin
      arvalid_d = 1'b1;
      arid_d    = ent.tag;
      araddr_d  = ent.addr;
      arlen_d   = ent.len;
      arsize_d  = ent.size;
      arburst_d = ent.burst;
    end else if (ar_hs) begin
      arvalid_d = 1'b0;
    end
  end

  // Accept and beat always touch different tags: an accepted tag is idle.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    exp_d  = exp_q;
    cnt_d  = cnt_q;
    if (accept) begin
      busy_d[ent.tag] = 1'b1;
      err_d[ent.tag]  = 1'b0;
      exp_d[ent.tag]  = {1'b0, ent.len} + 5'd1;
      cnt_d[ent.tag]  = 5'd0;
    end
    if (beat_acc) begin
      cnt_d[axi.rid] = beat_n;
      err_d[axi.rid] = err_q[axi.rid] || r_nok;
      if (axi.rlast) busy_d[axi.rid] = 1'b0;
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (accept && !retire) outst_d = outst_q + 1'b1;
    if (!accept && retire) outst_d = outst_q - 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      busy_q    <= '0;
      err_q     <= '0;
      for (int i = 0; i < NT; i++) begin
        exp_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      outst_q <= '0;
      drop_q  <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      outst_q   <= outst_d;
      drop_q    <= drop;
      proto_q   <= stray || (beat_acc && beat_bad);
    end
  end

  assign axi.arvalid = arvalid_q;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'b0011;
  assign axi.arprot  = 3'b000;

  assign outst_cnt  = outst_q;
  assign drop_pulse = drop_q;
  assign proto_err  = proto_q;

endmodule
